// File: rtl/vwb_pkg.sv
// vwb_pkg: shared encodings, element write request type and SEW width helper for the writeback arbiter.
package vwb_pkg;
  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] LMUL_1 = 3'b000;
  localparam logic [2:0] LMUL_2 = 3'b001;
  localparam logic [2:0] LMUL_4 = 3'b010;
  typedef struct packed {
    logic [4:0]  vd;
    logic [4:0]  idx;
    logic [2:0]  sew;
    logic [31:0] data;
  } el_wr_req_t;
  function automatic logic [6:0] sew_to_width(input logic [2:0] sew);
    return sew == SEW_32 ? 7'd32 : sew == SEW_16 ? 7'd16 : 7'd8;
  endfunction
endpackage

// File: rtl/v_wb_el_fifo.sv
// v_wb_el_fifo: element write FIFO with flush and a one-hot OR of queued destination registers.
module v_wb_el_fifo
  import vwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  el_wr_req_t  din,
  output el_wr_req_t  dout,
  output logic        full,
  output logic        empty,
  output logic [31:0] pending_mask
);
  localparam int AW = $clog2(DEPTH);
  el_wr_req_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      pending_mask = pending_mask | (vld[i] ? 32'd1 << mem[i].vd : 32'd0);
  end
  // on a full push+pop wp==rp, so the later set of vld wins over the clear
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (do_pop) begin
        rp      <= rp + AW'(1);
        vld[rp] <= 1'b0;
      end
      if (do_push) begin
        wp      <= wp + AW'(1);
        vld[wp] <= 1'b1;
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/v_wb_arbiter.sv
// v_wb_arbiter: merges ALU group writes and buffered load element writes onto the regfile, one write per cycle.
module v_wb_arbiter
  import vwb_pkg::*;
#(
  parameter int EL_FIFO_DEPTH = 4,
  parameter int MAX_WAIT      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [4:0]   alu_vd,
  input  logic [2:0]   alu_lmul,
  input  logic [127:0] alu_data_1,
  input  logic [127:0] alu_data_2,
  input  logic [127:0] alu_data_3,
  input  logic [127:0] alu_data_4,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [4:0]   ld_vd,
  input  logic [4:0]   ld_idx,
  input  logic [2:0]   ld_sew,
  input  logic [31:0]  ld_data,
  output logic         reg_wr_en,
  output logic [4:0]   reg_wr_addr,
  output logic [127:0] reg_wr_data,
  output logic [127:0] reg_wr_data_2,
  output logic [127:0] reg_wr_data_3,
  output logic [127:0] reg_wr_data_4,
  output logic         el_wr_en,
  output logic [4:0]   el_reg_wr_addr,
  output logic [4:0]   el_wr_addr,
  output logic [127:0] el_wr_data,
  output logic [2:0]   wb_lmul,
  output logic [2:0]   wb_sew,
  output logic [31:0]  pending_mask
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  el_wr_req_t head, push_req;
  logic fifo_full, fifo_empty, push, force_el, alu_blocked, grant_el, grant_alu;
  logic [WW-1:0] wait_cnt;
  logic [31:0] g_mask, hazard_mask;
  logic [4:0] v1, v2, v3, el_k;
  logic [6:0] el_w;
  logic [31:0] el_val;
  logic [127:0] el_lane;
  logic unused_idx;
  assign push_req = '{vd: ld_vd, idx: ld_idx, sew: ld_sew, data: ld_data};
  v_wb_el_fifo #(.DEPTH(EL_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(grant_el), .din(push_req),
    .dout(head), .full(fifo_full), .empty(fifo_empty), .pending_mask(pending_mask)
  );
  assign v1 = alu_vd + 5'd1;
  assign v2 = alu_vd + 5'd2;
  assign v3 = alu_vd + 5'd3;
  assign g_mask = (32'd1 << alu_vd)
                | (alu_lmul == LMUL_2 || alu_lmul == LMUL_4 ? 32'd1 << v1 : 32'd0)
                | (alu_lmul == LMUL_4 ? (32'd1 << v2) | (32'd1 << v3) : 32'd0);
  assign force_el = wait_cnt >= WW'(MAX_WAIT) || fifo_full;
  // a full FIFO always forces a pop, so readiness never depends on the grant itself
  assign ld_ready = !rst && (!fifo_full || force_el);
  assign push = ld_valid && ld_ready && !flush;
  assign hazard_mask = pending_mask | (push ? 32'd1 << ld_vd : 32'd0);
  assign alu_blocked = |(hazard_mask & g_mask);
  assign grant_el = !rst && !flush && !fifo_empty && (force_el || !alu_valid || alu_blocked);
  assign grant_alu = !rst && alu_valid && !alu_blocked && !grant_el;
  assign alu_ready = grant_alu;
  assign el_k = head.sew == SEW_32 ? {3'b0, head.idx[1:0]} :
                head.sew == SEW_16 ? {2'b0, head.idx[2:0]} : {1'b0, head.idx[3:0]};
  assign el_w = sew_to_width(head.sew);
  assign el_val = head.data & (head.sew == SEW_32 ? 32'hffff_ffff :
                               head.sew == SEW_16 ? 32'h0000_ffff : 32'h0000_00ff);
  assign el_lane = {96'd0, el_val} << (7'(el_k) * el_w);
  assign unused_idx = head.idx[4];
  always_ff @(posedge clk)
    if (rst || flush || grant_el || fifo_empty) wait_cnt <= '0;
    else if (wait_cnt < WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      reg_wr_data_2  <= '0;
      reg_wr_data_3  <= '0;
      reg_wr_data_4  <= '0;
      el_wr_en       <= 1'b0;
      el_reg_wr_addr <= '0;
      el_wr_addr     <= '0;
      el_wr_data     <= '0;
      wb_lmul        <= '0;
      wb_sew         <= '0;
    end else begin
      reg_wr_en <= grant_alu;
      el_wr_en  <= grant_el;
      if (grant_alu) begin
        reg_wr_addr   <= alu_vd;
        reg_wr_data   <= alu_data_1;
        reg_wr_data_2 <= alu_data_2;
        reg_wr_data_3 <= alu_data_3;
        reg_wr_data_4 <= alu_data_4;
        wb_lmul       <= alu_lmul;
        wb_sew        <= SEW_8;
      end
      if (grant_el) begin
        el_reg_wr_addr <= head.vd;
        el_wr_addr     <= el_k;
        el_wr_data     <= el_lane;
        wb_lmul        <= LMUL_1;
        wb_sew         <= head.sew;
      end
    end
endmodule

// File: tb/tb_v_wb_arbiter.sv
// tb_v_wb_arbiter: directed stimulus with a scoreboard of expected register and element writes.
module tb_v_wb_arbiter;
  logic clk, rst, flush, alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0] alu_vd, ld_vd, ld_idx;
  logic [2:0] alu_lmul, ld_sew, wb_lmul, wb_sew;
  logic [127:0] alu_data_1, alu_data_2, alu_data_3, alu_data_4;
  logic [31:0] ld_data, pending_mask;
  logic reg_wr_en, el_wr_en;
  logic [4:0] reg_wr_addr, el_reg_wr_addr, el_wr_addr;
  logic [127:0] reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4, el_wr_data;

  typedef struct {logic [4:0] vd; logic [2:0] lmul; logic [127:0] d1, d2, d3, d4;} reg_exp_t;
  typedef struct {logic [4:0] vd; logic [4:0] k; logic [2:0] sew; logic [127:0] d;} el_exp_t;
  reg_exp_t regq[$];
  el_exp_t elq[$];
  int passed = 0, total = 0, n_el = 0, got = 0;
  logic s_alu_ready, s_ld_ready;

  v_wb_arbiter #(.EL_FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vd(alu_vd), .alu_lmul(alu_lmul),
    .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_data_3(alu_data_3), .alu_data_4(alu_data_4),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_vd(ld_vd), .ld_idx(ld_idx), .ld_sew(ld_sew), .ld_data(ld_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_data_2(reg_wr_data_2), .reg_wr_data_3(reg_wr_data_3), .reg_wr_data_4(reg_wr_data_4),
    .el_wr_en(el_wr_en), .el_reg_wr_addr(el_reg_wr_addr), .el_wr_addr(el_wr_addr), .el_wr_data(el_wr_data),
    .wb_lmul(wb_lmul), .wb_sew(wb_sew), .pending_mask(pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic el_exp_t exp_el(input logic [4:0] vd, input logic [4:0] idx,
                                     input logic [2:0] sew, input logic [31:0] d);
    int w, k;
    w = (sew == 3'b001) ? 16 : (sew == 3'b010) ? 32 : 8;
    k = int'(idx) % (128 / w);
    exp_el.vd = vd;
    exp_el.k = 5'(k);
    exp_el.sew = sew;
    exp_el.d = '0;
    for (int b = 0; b < w; b++) exp_el.d[k*w+b] = d[b];
  endfunction

  // accepted requests are recorded before the edge; outputs are compared 1 time unit after it
  task automatic tick();
    reg_exp_t re;
    el_exp_t ee;
    @(negedge clk);
    s_alu_ready = alu_ready;
    s_ld_ready = ld_ready;
    if (rst) begin
      regq.delete();
      elq.delete();
    end else begin
      if (flush) elq.delete();
      if (alu_valid && alu_ready)
        regq.push_back('{alu_vd, alu_lmul, alu_data_1, alu_data_2, alu_data_3, alu_data_4});
      if (ld_valid && ld_ready && !flush) elq.push_back(exp_el(ld_vd, ld_idx, ld_sew, ld_data));
    end
    @(posedge clk);
    #1;
    n_el += int'(el_wr_en);
    chk("exclusive", 128'(reg_wr_en && el_wr_en), 128'(0));
    if (reg_wr_en) begin
      if (regq.size() == 0) chk("reg_unexpected", 128'(reg_wr_en), 128'(0));
      else begin
        re = regq.pop_front();
        chk("reg_addr", 128'(reg_wr_addr), 128'(re.vd));
        chk("reg_lmul", 128'(wb_lmul), 128'(re.lmul));
        chk("reg_sew", 128'(wb_sew), 128'(0));
        chk("reg_d1", reg_wr_data, re.d1);
        chk("reg_d2", reg_wr_data_2, re.d2);
        chk("reg_d3", reg_wr_data_3, re.d3);
        chk("reg_d4", reg_wr_data_4, re.d4);
      end
    end
    if (el_wr_en) begin
      if (elq.size() == 0) chk("el_unexpected", 128'(el_wr_en), 128'(0));
      else begin
        ee = elq.pop_front();
        chk("el_vd", 128'(el_reg_wr_addr), 128'(ee.vd));
        chk("el_lane", 128'(el_wr_addr), 128'(ee.k));
        chk("el_sew", 128'(wb_sew), 128'(ee.sew));
        chk("el_data", el_wr_data, ee.d);
      end
    end
  endtask

  task automatic set_alu(input logic v, input logic [4:0] vd, input logic [2:0] lmul);
    alu_valid = v;
    alu_vd = vd;
    alu_lmul = lmul;
    alu_data_1 = {4{$urandom}};
    alu_data_2 = {4{$urandom}};
    alu_data_3 = {4{$urandom}};
    alu_data_4 = {4{$urandom}};
  endtask

  task automatic set_ld(input logic v, input logic [4:0] vd, input logic [4:0] idx,
                        input logic [2:0] sew, input logic [31:0] d);
    ld_valid = v;
    ld_vd = vd;
    ld_idx = idx;
    ld_sew = sew;
    ld_data = d;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_alu(1'b1, 5'd0, 3'b000);
    set_ld(1'b1, 5'd0, 5'd0, 3'b000, 32'd0);
    tick();
    chk("rst_alu_ready", 128'(s_alu_ready), 128'(0));
    chk("rst_ld_ready", 128'(s_ld_ready), 128'(0));
    tick();
    chk("rst_reg_wr_en", 128'(reg_wr_en), 128'(0));
    chk("rst_el_wr_en", 128'(el_wr_en), 128'(0));
    chk("rst_pending", 128'(pending_mask), 128'(0));
    chk("rst_reg_addr", 128'(reg_wr_addr), 128'(0));
    chk("rst_reg_data", reg_wr_data, 128'(0));
    chk("rst_el_data", el_wr_data, 128'(0));
    chk("rst_wb_lmul", 128'(wb_lmul), 128'(0));
    chk("rst_wb_sew", 128'(wb_sew), 128'(0));
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 3'b000);
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    tick();
    // ALU group of four registers at v4
    set_alu(1'b1, 5'd4, 3'b010);
    tick();
    set_alu(1'b0, 5'd0, 3'b000);
    chk("alu_accept", 128'(s_alu_ready), 128'(1));
    chk("alu_wr_en", 128'(reg_wr_en), 128'(1));
    chk("alu_addr", 128'(reg_wr_addr), 128'(4));
    chk("alu_lmul", 128'(wb_lmul), 128'(3'b010));
    // element with 2-cycle latency, sew16 lane 3
    set_ld(1'b1, 5'd7, 5'd3, 3'b001, 32'h0000_beef);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("el_latency", 128'(el_wr_en), 128'(0));
    chk("el_pending", 128'(pending_mask), 128'(32'h80));
    tick();
    chk("el_wr_en", 128'(el_wr_en), 128'(1));
    chk("el_beef", el_wr_data, 128'h0000_beef << 48);
    chk("el_idx3", 128'(el_wr_addr), 128'(3));
    chk("el_vd7", 128'(el_reg_wr_addr), 128'(7));
    chk("el_pending_clr", 128'(pending_mask), 128'(0));
    // hazard: v9 element pushed with ALU v8..v9 in the same cycle
    set_ld(1'b1, 5'd9, 5'd0, 3'b000, 32'h55);
    set_alu(1'b1, 5'd8, 3'b001);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("haz_push_block", 128'(s_alu_ready), 128'(0));
    tick();
    chk("haz_queued_block", 128'(s_alu_ready), 128'(0));
    chk("haz_el_first", 128'(el_wr_en), 128'(1));
    chk("haz_pending9", 128'(pending_mask), 128'(0));
    tick();
    chk("haz_alu_after", 128'(s_alu_ready), 128'(1));
    chk("haz_reg_wr", 128'(reg_wr_en), 128'(1));
    // wait-counter starvation limit under continuous ALU traffic
    set_alu(1'b1, 5'd0, 3'b000);
    set_ld(1'b1, 5'd20, 5'd2, 3'b010, 32'hcafe_f00d);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("starve_alu_first", 128'(s_alu_ready), 128'(1));
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      set_alu(1'b1, 5'd0, 3'b000);
      tick();
      if (el_wr_en && got == 0) got = i;
    end
    chk("starve_forced_cycle", 128'(got), 128'(9));
    // fill to four, then push while full with the forced pop
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'd0, 3'b000);
      set_ld(1'b1, 5'(10 + i), 5'(i), 3'b000, 32'(8'h10 + i));
      tick();
    end
    chk("full_pending", 128'(pending_mask), 128'(32'h3c00));
    set_ld(1'b1, 5'd14, 5'd15, 3'b000, 32'h0000_00a5);
    tick();
    chk("full_alu_denied", 128'(s_alu_ready), 128'(0));
    chk("full_ld_ready", 128'(s_ld_ready), 128'(1));
    chk("full_pop", 128'(el_wr_en), 128'(1));
    chk("full_occupancy", 128'(pending_mask), 128'(32'h7800));
    set_alu(1'b0, 5'd0, 3'b000);
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    n_el = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("full_drain_count", 128'(n_el), 128'(4));
    chk("full_drain_pending", 128'(pending_mask), 128'(0));
    // flush with three queued entries
    for (int i = 1; i <= 3; i++) begin
      set_alu(1'b1, 5'd0, 3'b000);
      set_ld(1'b1, 5'(i), 5'(i), 3'b001, 32'(i));
      tick();
    end
    chk("flush_pending_pre", 128'(pending_mask), 128'(32'he));
    set_alu(1'b0, 5'd0, 3'b000);
    set_ld(1'b1, 5'd5, 5'd0, 3'b000, 32'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("flush_ld_ready", 128'(s_ld_ready), 128'(1));
    chk("flush_el_wr_en", 128'(el_wr_en), 128'(0));
    chk("flush_pending", 128'(pending_mask), 128'(0));
    n_el = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("flush_no_issue", 128'(n_el), 128'(0));
    // reset mid-stream
    for (int i = 0; i < 2; i++) begin
      set_alu(1'b1, 5'd0, 3'b000);
      set_ld(1'b1, 5'(6 + i), 5'd0, 3'b000, 32'h1);
      tick();
    end
    rst = 1'b1;
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    tick();
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 3'b000);
    chk("mrst_reg_wr_en", 128'(reg_wr_en), 128'(0));
    chk("mrst_el_wr_en", 128'(el_wr_en), 128'(0));
    chk("mrst_pending", 128'(pending_mask), 128'(0));
    n_el = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("mrst_no_issue", 128'(n_el), 128'(0));
    // sew32 index 17 lands in lane 1; an unknown sew acts as sew8
    set_ld(1'b1, 5'd3, 5'd17, 3'b010, 32'h1234_5678);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    tick();
    chk("sew32_lane", 128'(el_wr_addr), 128'(1));
    chk("sew32_data", el_wr_data, 128'h1234_5678 << 32);
    chk("sew32_wb_sew", 128'(wb_sew), 128'(3'b010));
    set_ld(1'b1, 5'd2, 5'd5, 3'b111, 32'haabb_ccdd);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    tick();
    chk("sew_other_lane", 128'(el_wr_addr), 128'(5));
    chk("sew_other_data", el_wr_data, 128'hdd << 40);
    chk("sew_other_wb_sew", 128'(wb_sew), 128'(3'b111));
    // group v31..v2 wraps onto a pending v1
    set_ld(1'b1, 5'd1, 5'd0, 3'b000, 32'h9);
    set_alu(1'b1, 5'd31, 3'b010);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("wrap_block", 128'(s_alu_ready), 128'(0));
    tick();
    chk("wrap_block_2", 128'(s_alu_ready), 128'(0));
    tick();
    chk("wrap_accept", 128'(s_alu_ready), 128'(1));
    chk("wrap_reg_addr", 128'(reg_wr_addr), 128'(31));
    // an unknown lmul covers one register only, so v31 pending does not block v30
    set_ld(1'b1, 5'd31, 5'd0, 3'b000, 32'h3);
    set_alu(1'b1, 5'd30, 3'b111);
    tick();
    set_ld(1'b0, 5'd0, 5'd0, 3'b000, 32'd0);
    set_alu(1'b0, 5'd0, 3'b000);
    chk("lmul_other_ok", 128'(s_alu_ready), 128'(1));
    for (int i = 0; i < 3; i++) tick();
    chk("regq_empty", 128'(regq.size()), 128'(0));
    chk("elq_empty", 128'(elq.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
